// File: rtl/rv32i_decoder.sv
// RV32I instruction decoder: register fields, immediate generation and ALU control
// for OP / OP-IMM, plus a sticky flag remembering any unsupported instruction.
module rv32i_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        reg_write,
    output logic        alu_src_imm,
    output logic [3:0]  alu_op,
    output logic        illegal,
    output logic        illegal_seen
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_f7Zero;
    logic        w_f7Alt;
    logic        w_isShift;
    logic [3:0]  w_baseOp;
    logic [31:0] w_immI;
    logic        r_illegalSeen;

    assign w_opcode  = instr[6:0];
    assign w_funct3  = instr[14:12];
    assign w_funct7  = instr[31:25];
    assign w_f7Zero  = (w_funct7 == 7'b0000000);
    assign w_f7Alt   = (w_funct7 == 7'b0100000);
    assign w_isShift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    assign w_immI    = {{20{instr[31]}}, instr[31:20]};

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    // funct3 mapping shared by OP and OP-IMM; funct7 variants are applied afterwards
    always_comb begin
        w_baseOp = ALU_ADD;
        case (w_funct3)
            3'b000:  w_baseOp = ALU_ADD;
            3'b001:  w_baseOp = ALU_SLL;
            3'b010:  w_baseOp = ALU_SLT;
            3'b011:  w_baseOp = ALU_SLTU;
            3'b100:  w_baseOp = ALU_XOR;
            3'b101:  w_baseOp = ALU_SRL;
            3'b110:  w_baseOp = ALU_OR;
            default: w_baseOp = ALU_AND;
        endcase
    end

    always_comb begin
        imm         = 32'd0;
        reg_write   = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        illegal     = 1'b1;
        case (w_opcode)
            OPC_OP: begin
                if (w_f7Zero || (w_f7Alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
                    reg_write = 1'b1;
                    illegal   = 1'b0;
                    if (w_f7Alt)
                        alu_op = (w_funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                    else
                        alu_op = w_baseOp;
                end
            end
            OPC_OPIMM: begin
                // Shift immediates carry funct7 in the upper bits, so only shamt is exposed
                if (w_isShift) begin
                    imm = {27'd0, instr[24:20]};
                    if (w_f7Zero) begin
                        reg_write   = 1'b1;
                        alu_src_imm = 1'b1;
                        illegal     = 1'b0;
                        alu_op      = w_baseOp;
                    end else if (w_f7Alt && w_funct3 == 3'b101) begin
                        reg_write   = 1'b1;
                        alu_src_imm = 1'b1;
                        illegal     = 1'b0;
                        alu_op      = ALU_SRA;
                    end
                end else begin
                    imm         = w_immI;
                    reg_write   = 1'b1;
                    alu_src_imm = 1'b1;
                    illegal     = 1'b0;
                    alu_op      = w_baseOp;
                end
            end
            OPC_LOAD, OPC_JALR: imm = w_immI;
            OPC_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'd0};
            OPC_JAL:    imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_illegalSeen <= 1'b0;
        else
            r_illegalSeen <= r_illegalSeen | illegal;
    end

    assign illegal_seen = r_illegalSeen;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Scoreboard bench for rv32i_decoder: stimulus pushes reference-model expectations,
// a negedge monitor pops them and compares against the DUT outputs.
module tb_rv32i_decoder;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        regWrite;
        logic        srcImm;
        logic [3:0]  aluOp;
        logic        illegal;
        logic        seen;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        reg_write;
    logic        alu_src_imm;
    logic [3:0]  alu_op;
    logic        illegal;
    logic        illegal_seen;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    logic modelSeen = 1'b0;

    rv32i_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .imm          (imm),
        .reg_write    (reg_write),
        .alu_src_imm  (alu_src_imm),
        .alu_op       (alu_op),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decode rules expressed as table lookups and integer arithmetic
    function automatic exp_t modelDecode(input logic [31:0] ins);
        exp_t e;
        int   opTable[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        int   f3 = int'(ins[14:12]);
        int   f7 = int'(ins[31:25]);
        int   opc = int'(ins[6:0]);
        int   v;
        int   immI;
        bit   shift;
        bit   ok;
        immI = int'(ins[31:20]);
        if (immI >= 2048) immI -= 4096;
        e.instr = ins;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.imm = 32'd0;
        e.regWrite = 1'b0;
        e.srcImm = 1'b0;
        e.aluOp = 4'd0;
        e.illegal = 1'b1;
        e.seen = 1'b0;
        if (opc == 'h33) begin
            if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) begin
                e.regWrite = 1'b1;
                e.illegal = 1'b0;
                e.aluOp = 4'(opTable[f3] + ((f7 == 32) ? 1 : 0));
            end
        end else if (opc == 'h13) begin
            shift = (f3 == 1 || f3 == 5);
            e.imm = shift ? 32'(int'(ins[24:20])) : 32'(immI);
            ok = !shift || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 32));
            if (ok) begin
                e.regWrite = 1'b1;
                e.srcImm = 1'b1;
                e.illegal = 1'b0;
                e.aluOp = 4'(opTable[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0));
            end
        end else if (opc == 'h03 || opc == 'h67) begin
            e.imm = 32'(immI);
        end else if (opc == 'h23) begin
            v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
            if (v >= 2048) v -= 4096;
            e.imm = 32'(v);
        end else if (opc == 'h63) begin
            v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            if (v >= 4096) v -= 8192;
            e.imm = 32'(v);
        end else if (opc == 'h37 || opc == 'h17) begin
            e.imm = ins & 32'hFFFF_F000;
        end else if (opc == 'h6F) begin
            v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12) + int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
            if (v >= (1 << 20)) v -= (1 << 21);
            e.imm = 32'(v);
        end
        return e;
    endfunction

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] iType(input logic [11:0] i12, input logic [2:0] f3,
                                          input logic [4:0] r1, input logic [4:0] d);
        return {i12, r1, f3, d, 7'b0010011};
    endfunction

    // Drive one instruction just after a rising edge and queue what the DUT should show
    task automatic applyStimulus(input logic [31:0] ins, input logic rstVal);
        exp_t e;
        @(posedge clk);
        #1;
        instr = ins;
        rst = rstVal;
        e = modelDecode(ins);
        e.seen = modelSeen;
        expQ.push_back(e);
        modelSeen = rstVal ? 1'b0 : (modelSeen | e.illegal);
    endtask

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] req,
                                input logic [31:0] ins);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s instr=%h actual=%h required=%h", name, ins, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("rs1", 32'(rs1), 32'(e.rs1), e.instr);
        compareField("rs2", 32'(rs2), 32'(e.rs2), e.instr);
        compareField("rd", 32'(rd), 32'(e.rd), e.instr);
        compareField("imm", imm, e.imm, e.instr);
        compareField("reg_write", 32'(reg_write), 32'(e.regWrite), e.instr);
        compareField("alu_src_imm", 32'(alu_src_imm), 32'(e.srcImm), e.instr);
        compareField("alu_op", 32'(alu_op), 32'(e.aluOp), e.instr);
        compareField("illegal", 32'(illegal), 32'(e.illegal), e.instr);
        compareField("illegal_seen", 32'(illegal_seen), 32'(e.seen), e.instr);
    endtask

    // Monitor: every negedge the DUT shows a decoded result for the instruction queued last
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        errors++;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [6:0]  sweepF7[10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
        logic [2:0]  sweepF3[10] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5, 3'd2, 3'd3};
        logic [6:0]  opcList[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F};
        logic [6:0]  f7List[4]   = '{7'h00, 7'h20, 7'h01, 7'h7F};
        logic [31:0] r;
        rst = 1'b1;
        instr = 32'd0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 10; i++)
            applyStimulus(rType(sweepF7[i], sweepF3[i], 5'd1, 5'd2, 5'd3), 1'b0);
        applyStimulus(iType(12'd10, 3'd0, 5'd1, 5'd5), 1'b0);
        applyStimulus(iType(12'hFFF, 3'd7, 5'd1, 5'd6), 1'b0);
        applyStimulus(iType({7'b0100000, 5'd4}, 3'd5, 5'd1, 5'd7), 1'b0);
        applyStimulus(iType(12'h400, 3'd0, 5'd1, 5'd8), 1'b0);
        applyStimulus(iType({7'b0100000, 5'd3}, 3'd1, 5'd1, 5'd8), 1'b0);

        applyStimulus(rType(7'h01, 3'd0, 5'd1, 5'd2, 5'd3), 1'b0);
        applyStimulus(rType(7'h00, 3'd0, 5'd1, 5'd2, 5'd3), 1'b0);
        applyStimulus(rType(7'h00, 3'd0, 5'd1, 5'd2, 5'd3), 1'b0);
        applyStimulus(rType(7'h00, 3'd0, 5'd1, 5'd2, 5'd3), 1'b1);
        applyStimulus(rType(7'h00, 3'd0, 5'd1, 5'd2, 5'd3), 1'b0);
        applyStimulus(32'h0000_2083, 1'b0);
        applyStimulus(32'h0000_2083, 1'b1);
        applyStimulus(rType(7'h00, 3'd4, 5'd4, 5'd5, 5'd6), 1'b0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: r[6:0] = opcList[$urandom_range(0, 9)];
                1: begin
                    r[6:0] = 7'h33;
                    r[31:25] = f7List[$urandom_range(0, 3)];
                end
                2: begin
                    r[6:0] = 7'h13;
                    r[31:25] = f7List[$urandom_range(0, 3)];
                end
                default: ;
            endcase
            applyStimulus(r, ($urandom_range(0, 15) == 0));
        end

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d required=0 pending", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_decoder.md
Name: rv32i_decoder

Overview:
- Instruction decoder for the single-cycle RV32I CPU; sits between instruction fetch and the register file / ALU.
- Splits a 32-bit instruction into register fields and a sign- or zero-extended immediate.
- Drives ALU control (operation, operand-B select, register write enable) for OP (0110011) and OP-IMM (0010011) instructions.
- Decode is purely combinational; the only state is a sticky illegal-instruction flag.

Parameters:
- None.

Ports:
- clk  input  1  system clock; used only by the sticky flag register
- rst  input  1  synchronous active-high reset
- instr  input  32  instruction word
- rs1  output  5  instr[19:15], always raw
- rs2  output  5  instr[24:20], always raw, even for I-type
- rd  output  5  instr[11:7], always raw
- imm  output  32  decoded immediate
- reg_write  output  1  write rd this cycle
- alu_src_imm  output  1  1 = ALU operand B is imm; 0 = rs2 data
- alu_op  output  4  ALU operation code
- illegal  output  1  combinational: current instr is not a supported OP/OP-IMM encoding
- illegal_seen  output  1  registered sticky OR of illegal

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- alu_op encoding:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - Values A–F are never driven.
- All outputs except illegal_seen are combinational from instr, with zero latency. They are valid within the same cycle and are independent of clk and rst.
- Register fields: rs1, rs2 and rd are extracted for every opcode, with no masking.
- OP (0110011):
  - reg_write=1, alu_src_imm=0, imm=0.
  - funct3 decode: 000→ADD, or SUB if funct7=0100000; 001→SLL; 010→SLT; 011→SLTU; 100→XOR; 101→SRL, or SRA if funct7=0100000; 110→OR; 111→AND.
  - funct7 must be 0000000. 0100000 is additionally allowed only for funct3 000 and 101. Any other funct7 is illegal.
- OP-IMM (0010011):
  - reg_write=1, alu_src_imm=1.
  - Same funct3 mapping as OP, except funct3 000 is always ADD (no SUBI).
  - Non-shift forms (funct3 ≠ 001/101): imm = sign-extended instr[31:20]; funct7 bits are part of the immediate and are ignored.
  - SLLI (001): funct7 must be 0000000.
  - SRLI/SRAI (101): funct7 0000000→SRL, 0100000→SRA, anything else illegal.
  - Shift forms: imm = zero-extended shamt instr[24:20]. Example: SRAI shamt 4 gives imm=4, not 0x404.
- Immediate for other formats (for downstream use; the ALU-class outputs stay inactive):
  - LOAD/JALR: I-format, sign-extended.
  - STORE: S-format {instr[31:25], instr[11:7]}, sign-extended.
  - BRANCH: B-format {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - LUI/AUIPC: U-format {instr[31:12], 12'b0}.
  - JAL: J-format {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - Any other opcode: imm=0.
- Illegal / non-ALU-class instructions:
  - Any opcode other than OP/OP-IMM, or an illegal funct7: reg_write=0, alu_src_imm=0, alu_op=ADD.
  - illegal=1 for every opcode other than OP/OP-IMM, and for illegal funct7.
  - No X ever propagates on any output for any instr value.
- illegal_seen:
  - On each rising clk: rst=1 → 0; else illegal_seen ← illegal_seen | illegal.
  - rst has priority when asserted in the same cycle as illegal.
  - Reset value 0.
  - Only cleared by rst.

Test Plan:
- R-type sweep with rs1=1, rs2=2, rd=3: ADD, SUB (funct7 0100000), AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU. Each → reg_write=1, alu_src_imm=0, matching alu_op 0,1,2,3,4,5,6,7,8,9, rs1=1, rs2=2, rd=3, imm=0.
- addi x5,x1,10 → reg_write=1, alu_src_imm=1, alu_op=0, rs1=1, rs2=10, rd=5, imm=0x0000000A.
- andi x6,x1,0xFFF → alu_op=2, rs2=0x1F, rd=6, imm=0xFFFFFFFF.
- srai x7,x1,4 (funct7 0100000) → alu_op=7, rs2=4, rd=7, imm=4.
- addi with imm bit30 set (imm 0x400) → alu_op=ADD, not SUB; imm=0x400.
- R-type with funct7=0000001, or opcode 0000011 → reg_write=0, illegal=1. Clock once → illegal_seen=1. Apply legal instr and clock → stays 1. Assert rst for one clock → 0.
